// File: rtl/mem_dump_engine_pkg.sv
// Shared types and default-configuration constants for the memory-dump engine.
// Modules derive their own sizes from their parameters with the helper below.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        FILL,
        EMIT,
        DONE
    } dump_state_e;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_DUMP_WORDS     = 4096;
    localparam logic [31:0] DEF_TRIG_ADDR = 32'h0000_000c;

    localparam int LINES     = DEF_DUMP_WORDS / DEF_WORDS_PER_LINE;
    localparam int LINE_W    = DEF_WORDS_PER_LINE * DEF_DATA_W;
    localparam int TRIG_WIDX = int'(DEF_TRIG_ADDR >> 2);

    // Bit width needed to index n items; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_dump_engine_if.sv
// Valid/ready line stream from the dump engine to its sink.
interface mem_dump_engine_if #(
    parameter int LINE_W = 128,
    parameter int IDX_W  = 10
);
    logic              line_valid;
    logic              line_ready;
    logic [LINE_W-1:0] line_data;
    logic [IDX_W-1:0]  line_index;

    modport master (output line_valid, output line_data, output line_index, input line_ready);
    modport slave  (input line_valid, input line_data, input line_index, output line_ready);
endinterface

// File: rtl/mem_dump_engine_packer.sv
// Line register for the dump engine: one slot written per returned BRAM word,
// with the trigger-store data substituted for the trigger word.
module dump_line_packer #(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_AW         = 12,
    parameter int ADDR_W         = 32,
    parameter int SLOT_W         = 2,
    parameter logic [ADDR_W-1:0] TRIG_WORD = '0
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             cap_en,
    input  logic                             hold,
    input  logic [SLOT_W-1:0]                cap_slot,
    input  logic [MEM_AW-1:0]                cap_widx,
    input  logic [DATA_W-1:0]                rd_data,
    input  logic [DATA_W-1:0]                trig_data,
    output logic [WORDS_PER_LINE*DATA_W-1:0] line_data
);

    logic [DATA_W-1:0] word_in;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        word_in = rd_data;
        if (ADDR_W'(cap_widx) == TRIG_WORD)
            word_in = trig_data;
    end

    // Word 0 of a line lands in the most-significant slot.
    always_ff @(posedge clk) begin
        if (!resetn)
            line_data <= '0;
        else if (cap_en && !hold)
            line_data[(WORDS_PER_LINE-1-int'(cap_slot))*DATA_W +: DATA_W] <= word_in;
    end

endmodule

// File: rtl/mem_dump_engine.sv
// Snoops CPU stores; on the trigger store it stalls the CPU, walks a BRAM word
// range and streams it out as packed lines with the trigger data substituted.
module mem_dump_engine
    import mem_dump_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MEM_AW         = 12,
    parameter int WORDS_PER_LINE = 4,
    parameter int DUMP_BASE      = 0,
    parameter int DUMP_WORDS     = 4096,
    parameter logic [ADDR_W-1:0] TRIG_ADDR = 'h0000000c
) (
    input  logic              mips_cpu_clk,
    input  logic              mips_cpu_resetn,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_data,
    input  logic              arm,
    output logic              cpu_stall,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    mem_dump_engine_if.master line
);

    localparam int N_LINES   = DUMP_WORDS / WORDS_PER_LINE;
    localparam int LINE_BITS = WORDS_PER_LINE * DATA_W;
    localparam int IDX_W     = width_of(N_LINES);
    localparam int SLOT_W    = width_of(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] TRIG_WORD = TRIG_ADDR >> 2;

    dump_state_e       state;
    logic              armed;
    logic [DATA_W-1:0] trig_data;
    logic [SLOT_W-1:0] rd_cnt;
    logic              line_valid_q;
    logic [IDX_W-1:0]  line_index_q;
    logic              trigger;

    logic              cap_en;
    logic [SLOT_W-1:0] cap_slot;
    logic [MEM_AW-1:0] cap_widx;
    logic [LINE_BITS-1:0] line_data_w;

    assign trigger = MemWrite && (Address == TRIG_ADDR) && armed && (state == IDLE);

    always_ff @(posedge mips_cpu_clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked block; all state updates use <=.
        if (!mips_cpu_resetn) begin
            state        <= IDLE;
            armed        <= 1'b1;
            trig_data    <= '0;
            rd_cnt       <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            line_valid_q <= 1'b0;
            line_index_q <= '0;
            busy         <= 1'b0;
            cpu_stall    <= 1'b0;
            done         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm)
                        armed <= 1'b1;
                    if (trigger) begin
                        trig_data    <= Write_data;
                        armed        <= 1'b0;
                        rd_cnt       <= '0;
                        mem_rd_en    <= 1'b1;
                        mem_rd_addr  <= MEM_AW'(DUMP_BASE);
                        line_index_q <= '0;
                        busy         <= 1'b1;
                        cpu_stall    <= 1'b1;
                        state        <= READ;
                    end
                end
                READ: begin
                    if (rd_cnt == SLOT_W'(WORDS_PER_LINE - 1)) begin
                        mem_rd_en <= 1'b0;
                        state     <= FILL;
                    end else begin
                        rd_cnt      <= rd_cnt + 1'b1;
                        mem_rd_addr <= mem_rd_addr + 1'b1;
                    end
                end
                FILL: begin
                    line_valid_q <= 1'b1;
                    state        <= EMIT;
                end
                EMIT: begin
                    if (line.line_ready) begin
                        line_valid_q <= 1'b0;
                        if (line_index_q == IDX_W'(N_LINES - 1)) begin
                            busy      <= 1'b0;
                            cpu_stall <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            line_index_q <= line_index_q + 1'b1;
                            mem_rd_addr  <= mem_rd_addr + 1'b1;
                            rd_cnt       <= '0;
                            mem_rd_en    <= 1'b1;
                            state        <= READ;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        armed <= 1'b1;
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM data arrives one cycle after the read, so slot and word index travel with it.
    always_ff @(posedge mips_cpu_clk) begin
        if (!mips_cpu_resetn) begin
            cap_en   <= 1'b0;
            cap_slot <= '0;
            cap_widx <= '0;
        end else begin
            cap_en   <= mem_rd_en;
            cap_slot <= rd_cnt;
            cap_widx <= mem_rd_addr;
        end
    end

    dump_line_packer #(
        .DATA_W         (DATA_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .MEM_AW         (MEM_AW),
        .ADDR_W         (ADDR_W),
        .SLOT_W         (SLOT_W),
        .TRIG_WORD      (TRIG_WORD)
    ) u_packer (
        .clk       (mips_cpu_clk),
        .resetn    (mips_cpu_resetn),
        .cap_en    (cap_en),
        .hold      (line_valid_q && !line.line_ready),
        .cap_slot  (cap_slot),
        .cap_widx  (cap_widx),
        .rd_data   (mem_rd_data),
        .trig_data (trig_data),
        .line_data (line_data_w)
    );

    assign line.line_valid = line_valid_q;
    assign line.line_index = line_index_q;
    assign line.line_data  = line_data_w;

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: default configuration plus a small
// offset configuration whose range excludes the trigger word.
module tb_mem_dump_engine;
    import mem_dump_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   total = 0;
    int   bad   = 0;

    // Default-configuration DUT
    logic        mw, arm1;
    logic [31:0] addr, wdata;
    logic        stall, rd_en, busy, done;
    logic [11:0] rd_addr;
    logic [31:0] rd_data = '0;
    mem_dump_engine_if #(.LINE_W(LINE_W), .IDX_W(10)) lif ();

    mem_dump_engine dut (
        .mips_cpu_clk    (clk),
        .mips_cpu_resetn (rstn),
        .MemWrite        (mw),
        .Address         (addr),
        .Write_data      (wdata),
        .arm             (arm1),
        .cpu_stall       (stall),
        .mem_rd_en       (rd_en),
        .mem_rd_addr     (rd_addr),
        .mem_rd_data     (rd_data),
        .busy            (busy),
        .done            (done),
        .line            (lif.master)
    );

    // Offset configuration: words 16..23, two words per line
    logic        mw2, arm2;
    logic [31:0] addr2, wdata2;
    logic        stall2, rd_en2, busy2, done2;
    logic [11:0] rd_addr2;
    logic [31:0] rd_data2 = '0;
    mem_dump_engine_if #(.LINE_W(64), .IDX_W(2)) lif2 ();

    mem_dump_engine #(.WORDS_PER_LINE(2), .DUMP_BASE(16), .DUMP_WORDS(8)) dut2 (
        .mips_cpu_clk    (clk),
        .mips_cpu_resetn (rstn),
        .MemWrite        (mw2),
        .Address         (addr2),
        .Write_data      (wdata2),
        .arm             (arm2),
        .cpu_stall       (stall2),
        .mem_rd_en       (rd_en2),
        .mem_rd_addr     (rd_addr2),
        .mem_rd_data     (rd_data2),
        .busy            (busy2),
        .done            (done2),
        .line            (lif2.master)
    );

    // BRAM model, word[i] = i, one-cycle read latency
    logic [31:0] mem [4096];
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en2) rd_data2 <= mem[rd_addr2];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rstn = 1'b0;
        mw = 0; arm1 = 0; addr = '0; wdata = '0;
        mw2 = 0; arm2 = 0; addr2 = '0; wdata2 = '0;
        lif.line_ready = 1'b1;
        lif2.line_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({stall, rd_en, busy, done, lif.line_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=00000", {stall, rd_en, busy, done, lif.line_valid});
        end
        total++;
        if (rd_addr !== 12'h0 || lif.line_index !== 10'h0) begin
            bad++; $display("FAIL reset_addr_idx got=%h/%h exp=0/0", rd_addr, lif.line_index);
        end
        total++;
        if (lif.line_data !== 128'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", lif.line_data);
        end
        total++;
        if ({stall2, rd_en2, busy2, done2, lif2.line_valid, rd_addr2, lif2.line_data, lif2.line_index} !== '0) begin
            bad++; $display("FAIL reset_dut2 got nonzero outputs data=%h", lif2.line_data);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_non_trigger;
        logic seen_stall, seen_rd;
        seen_stall = 0; seen_rd = 0;
        mw = 1; addr = 32'h8; wdata = 32'h1111_1111;
        @(negedge clk);
        addr = 32'h10; wdata = 32'h2222_2222;
        @(negedge clk);
        mw = 0; addr = '0; wdata = '0;
        for (int i = 0; i < 8; i++) begin
            seen_stall |= stall | busy;
            seen_rd    |= rd_en;
            @(negedge clk);
        end
        total++;
        if (seen_stall !== 1'b0) begin
            bad++; $display("FAIL non_trig_stall got=%b exp=0", seen_stall);
        end
        total++;
        if (seen_rd !== 1'b0) begin
            bad++; $display("FAIL non_trig_rd got=%b exp=0", seen_rd);
        end
    endtask

    // Triggers a dump on the default DUT and checks every emitted line.
    task automatic run_dump(input logic [31:0] data, input int stall_line, input int stall_cycles,
                            output int cycles, output int lines, output int first_valid,
                            output logic [127:0] first_line, output logic [127:0] last_line);
        int           hold;
        logic         after_stall;
        logic [127:0] snap, exp;
        hold = 0; after_stall = 0; lines = 0; first_valid = -1;
        snap = '0; first_line = '0; last_line = '0;
        mw = 1; addr = 32'hc; wdata = data;
        @(negedge clk);
        mw = 0; addr = '0; wdata = '0;
        cycles = 0;
        total++;
        if ({stall, busy, rd_en} !== 3'b111 || rd_addr !== 12'h0) begin
            bad++; $display("FAIL dump_start got=%b addr=%h exp=111 addr=0", {stall, busy, rd_en}, rd_addr);
        end
        while (done !== 1'b1 && cycles < 8000) begin
            if (after_stall) begin
                after_stall = 0;
                total++;
                if (rd_en !== 1'b1 || rd_addr !== 12'((stall_line + 1) * 4)) begin
                    bad++; $display("FAIL next_line_start got en=%b addr=%h exp en=1 addr=%h",
                                    rd_en, rd_addr, 12'((stall_line + 1) * 4));
                end
            end
            if (lif.line_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cycles;
                if (lines == stall_line && hold < stall_cycles) begin
                    if (hold == 0) snap = lif.line_data;
                    else begin
                        total++;
                        if (lif.line_data !== snap || lif.line_index !== 10'(stall_line) || rd_en !== 1'b0) begin
                            bad++; $display("FAIL hold_stable got=%h idx=%0d en=%b exp=%h idx=%0d en=0",
                                            lif.line_data, lif.line_index, rd_en, snap, stall_line);
                        end
                    end
                    hold++;
                    lif.line_ready = 1'b0;
                end else begin
                    lif.line_ready = 1'b1;
                    exp = {32'(lines * 4), 32'(lines * 4 + 1), 32'(lines * 4 + 2), 32'(lines * 4 + 3)};
                    if (lines == 0) exp[31:0] = data;
                    total++;
                    if (lif.line_data !== exp || lif.line_index !== 10'(lines)) begin
                        bad++; $display("FAIL line got=%h idx=%0d exp=%h idx=%0d",
                                        lif.line_data, lif.line_index, exp, lines);
                    end
                    if (lines == 0) first_line = lif.line_data;
                    last_line = lif.line_data;
                    if (stall_cycles > 0 && lines == stall_line) after_stall = 1;
                    lines++;
                end
            end
            @(negedge clk);
            cycles++;
        end
        lif.line_ready = 1'b1;
        total++;
        if (done !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL dump_end got done=%b stall=%b busy=%b exp 1/0/0", done, stall, busy);
        end
    endtask

    task automatic test_full_dump;
        int cycles, lines, fv;
        logic [127:0] l0, ll;
        run_dump(32'hdead_beef, -1, 0, cycles, lines, fv, l0, ll);
        total++;
        if (fv !== 5) begin
            bad++; $display("FAIL first_valid_cycle got=%0d exp=5", fv);
        end
        total++;
        if (lines !== LINES) begin
            bad++; $display("FAIL line_count got=%0d exp=%0d", lines, LINES);
        end
        total++;
        if (l0 !== 128'h00000000_00000001_00000002_deadbeef) begin
            bad++; $display("FAIL line0 got=%h exp=000000000000000100000002deadbeef", l0);
        end
        total++;
        if (ll !== 128'h00000ffc_00000ffd_00000ffe_00000fff) begin
            bad++; $display("FAIL line1023 got=%h exp=00000ffc00000ffd00000ffe00000fff", ll);
        end
        total++;
        if (cycles !== 6144) begin
            bad++; $display("FAIL dump_cycles got=%0d exp=6144", cycles);
        end
    endtask

    task automatic test_rearm;
        int cycles, lines, fv;
        logic [127:0] l0, ll;
        // Store to the trigger address while DONE: ignored
        mw = 1; addr = 32'hc; wdata = 32'h5555_5555;
        @(negedge clk);
        mw = 0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || stall !== 1'b0 || rd_en !== 1'b0) begin
            bad++; $display("FAIL store_in_done got done=%b stall=%b en=%b exp 1/0/0", done, stall, rd_en);
        end
        // Arm pulse together with a trigger store: the store is not taken
        arm1 = 1; mw = 1; addr = 32'hc; wdata = 32'h5555_5555;
        @(negedge clk);
        arm1 = 0; mw = 0; addr = '0;
        total++;
        if (done !== 1'b0 || stall !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL arm_to_idle got done=%b stall=%b busy=%b exp 0/0/0", done, stall, busy);
        end
        @(negedge clk);
        total++;
        if (rd_en !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL arm_cycle_trigger got en=%b stall=%b exp 0/0", rd_en, stall);
        end
        run_dump(32'h0000_1234, 3, 5, cycles, lines, fv, l0, ll);
        total++;
        if (l0 !== 128'h00000000_00000001_00000002_00001234) begin
            bad++; $display("FAIL rearm_line0 got=%h exp=00000000000000010000000200001234", l0);
        end
        total++;
        if (lines !== LINES || cycles !== 6149) begin
            bad++; $display("FAIL rearm_totals got lines=%0d cycles=%0d exp 1024/6149", lines, cycles);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        arm1 = 1;
        @(negedge clk);
        arm1 = 0;
        mw = 1; addr = 32'hc; wdata = 32'h0000_abcd;
        @(negedge clk);
        mw = 0; addr = '0;
        n = 0;
        while (!(lif.line_index === 10'd2 && rd_en === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (n >= 200) begin
            bad++; $display("FAIL reach_line2 got timeout exp line 2 reads");
        end
        rstn = 1'b0;
        @(negedge clk);
        total++;
        if ({stall, rd_en, busy, done, lif.line_valid} !== 5'b0 || rd_addr !== 12'h0 ||
            lif.line_index !== 10'h0 || lif.line_data !== 128'h0) begin
            bad++; $display("FAIL mid_reset got ctl=%b addr=%h idx=%0d data=%h exp all 0",
                            {stall, rd_en, busy, done, lif.line_valid}, rd_addr, lif.line_index, lif.line_data);
        end
        rstn = 1'b1;
        mw = 1; addr = 32'hc; wdata = 32'h0000_0077;
        @(negedge clk);
        mw = 0; addr = '0;
        total++;
        if (stall !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 12'h0 || lif.line_index !== 10'h0) begin
            bad++; $display("FAIL restart got stall=%b en=%b addr=%h idx=%0d exp 1/1/0/0",
                            stall, rd_en, rd_addr, lif.line_index);
        end
        n = 0;
        while (lif.line_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (lif.line_data !== 128'h00000000_00000001_00000002_00000077 || lif.line_index !== 10'h0) begin
            bad++; $display("FAIL restart_line0 got=%h idx=%0d exp=00000000000000010000000200000077 idx=0",
                            lif.line_data, lif.line_index);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_cfg;
        int cycles, lines;
        logic [63:0] exp;
        lines = 0;
        mw2 = 1; addr2 = 32'hc; wdata2 = 32'hdead_beef;
        @(negedge clk);
        mw2 = 0; addr2 = '0;
        cycles = 0;
        total++;
        if (stall2 !== 1'b1 || rd_addr2 !== 12'd16) begin
            bad++; $display("FAIL small_start got stall=%b addr=%0d exp 1/16", stall2, rd_addr2);
        end
        while (done2 !== 1'b1 && cycles < 100) begin
            if (lif2.line_valid === 1'b1) begin
                exp = {32'(16 + 2 * lines), 32'(17 + 2 * lines)};
                total++;
                if (lif2.line_data !== exp || lif2.line_index !== 2'(lines)) begin
                    bad++; $display("FAIL small_line got=%h idx=%0d exp=%h idx=%0d",
                                    lif2.line_data, lif2.line_index, exp, lines);
                end
                lines++;
            end
            @(negedge clk);
            cycles++;
        end
        total++;
        if (lines !== 4 || cycles !== 16 || stall2 !== 1'b0) begin
            bad++; $display("FAIL small_totals got lines=%0d cycles=%0d stall=%b exp 4/16/0",
                            lines, cycles, stall2);
        end
    endtask

    initial begin
        test_reset();
        test_non_trigger();
        test_full_dump();
        test_rearm();
        test_reset_mid();
        test_small_cfg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
